divider: RTL and testbench
==========================

Name: divider

Overview:
- Sequential restoring divider. It is the inverse-operation companion to the `multiplier` block.
- Computes `y = (a << FIXED_POINT) / b` and remainder `r`, one quotient bit per clock.
- Uses the same `trigger`/`ready`/`done` handshake as the multiplier, so synth control logic can time-share either block.
- Sits beside the multiplier in the envelope/pitch arithmetic path.

Parameters:
- `C_WIDTH`, 32, operand/result width in bits.
- `FIXED_POINT`, 0, number of fractional bits in `a`, `b` and `y`. 0 means integer division.

Ports:
- `ctl_clk`, in, 1, single clock, all logic on the rising edge.
- `reset`, in, 1, synchronous, active-low reset.
- `a`, in, `C_WIDTH`, dividend; sampled on the start edge.
- `b`, in, `C_WIDTH`, divisor; sampled on the start edge.
- `signed_cal`, in, 1, 1 = two's-complement operation, 0 = unsigned; sampled on the start edge.
- `trigger`, in, 1, start request, level-sampled.
- `y`, out, `C_WIDTH`, quotient, registered.
- `r`, out, `C_WIDTH`, remainder, registered.
- `ready`, out, 1, high when idle and able to accept `trigger`.
- `done`, out, 1, one-cycle pulse when `y`/`r` are valid.
- `div_by_zero`, out, 1, registered flag qualifying the last result.

Behaviour:
- Reset (`reset`=0 at an edge):
  - State goes to IDLE; iteration counter cleared.
  - `y`=0, `r`=0, `done`=0, `div_by_zero`=0.
  - `ready` = (state==IDLE) & `reset`, so `ready` is 0 while `reset` is low.
  - Reset mid-operation aborts the division; no `done` is produced.
- Let N = `C_WIDTH` + `FIXED_POINT`.
- States: IDLE, PREP, CALC, FIX.
- IDLE:
  - If `trigger`=1 at an edge, latch `a`, `b` and `signed_cal`, then go to PREP.
  - `trigger` in any other state is ignored. It is not queued.
- PREP (1 cycle):
  - If `signed_cal`=1, take absolute values of `a` and `b`.
  - Record `q_neg` = a_msb ^ b_msb and `r_neg` = a_msb. Both are 0 when unsigned.
  - Form the N-bit dividend `|a| << FIXED_POINT`.
  - Clear the partial remainder (`C_WIDTH`+1 bits) and load counter = N.
  - If `b`==0, go to FIX with the divide-by-zero path selected. Otherwise go to CALC.
- CALC (N cycles), per cycle:
  - Shift the next dividend MSB into the partial remainder.
  - If partial remainder >= |b|, subtract |b| and shift quotient bit 1; otherwise shift 0.
  - Decrement the counter; go to FIX after the cycle in which the counter reaches 1.
- FIX (1 cycle):
  - `y` = low `C_WIDTH` bits of (`q_neg` ? -Q : Q).
  - `r` = `r_neg` ? -R : R. The remainder sign follows the dividend (truncation toward zero).
  - `done`<=1, `div_by_zero`<=0, next state IDLE.
- Divide-by-zero path in FIX:
  - `y` = all ones, `r` = latched `a` unmodified.
  - `div_by_zero`<=1, `done`<=1.
- Latency, counted from the edge that samples `trigger`:
  - Normal: `done` is high in the cycle after edge N+2, i.e. N+3 edges total.
  - Divide by zero: 3 edges.
  - `ready` rises in the same cycle `done` is high.
- `done` is high exactly 1 cycle.
- `y`, `r` and `div_by_zero` hold their values until the next FIX or a reset.
- If `trigger` is still high in the `done` cycle, a new operation starts on that edge. Back-to-back operation is allowed.
- Overflow:
  - Quotient bits above `C_WIDTH` are discarded; wrap-around, no saturation.
  - Signed 0x80000000 / -1 yields `y`=0x80000000, `r`=0.
- Input changes on `a`/`b`/`signed_cal` after the start edge have no effect on the running operation.

Test Plan (`C_WIDTH`=32 unless stated):
1. Unsigned, `a`=0xee6c3250, `b`=0x1bca53c2, `trigger` pulsed 1 cycle -> `ready`=0 during the operation; after 35 edges `done`=1 for 1 cycle with `y`=0x00000008, `r`=0x10199440, `div_by_zero`=0.
2. Back-to-back:
   - Unsigned `a`=0x71, `b`=0xc2 -> `y`=0, `r`=0x71.
   - Then `signed_cal`=1, `a`=0xFFFFFFF9 (-7), `b`=2 -> `y`=0xFFFFFFFD, `r`=0xFFFFFFFF.
   - Then `a`=7, `b`=0xFFFFFFFE -> `y`=0xFFFFFFFD, `r`=1.
3. `a`=5, `b`=0 (either sign mode) -> `done` after 3 edges, `y`=0xFFFFFFFF, `r`=5, `div_by_zero`=1. Next valid division clears `div_by_zero`.
4. Signed `a`=0x80000000, `b`=0xFFFFFFFF -> `y`=0x80000000, `r`=0 after 35 edges.
5. `FIXED_POINT`=16 instance: `a`=0x00030000, `b`=0x00020000 -> after 51 edges `y`=0x00018000, `r`=0.
6. Control interference:
   - Start a division, pulse `trigger` again at CALC cycle 10 -> ignored; a single `done` with correct result.
   - Start again, drive `reset`=0 for 1 cycle at CALC cycle 5 -> next cycle `y`=0, `r`=0, `done`=0; `ready`=1 once `reset`=1.
   - Retrigger -> completes normally with the correct result.

Source files
------------

// File: rtl/divider.sv
// Sequential restoring divider: y = (a << FIXED_POINT) / b with remainder r,
// one quotient bit per clock, sharing the trigger/ready/done handshake of the multiplier.
module divider #(
    parameter int C_WIDTH     = 32,
    parameter int FIXED_POINT = 0
) (
    input  logic               ctl_clk,
    input  logic               reset,
    input  logic [C_WIDTH-1:0] a,
    input  logic [C_WIDTH-1:0] b,
    input  logic               signed_cal,
    input  logic               trigger,
    output logic [C_WIDTH-1:0] y,
    output logic [C_WIDTH-1:0] r,
    output logic               ready,
    output logic               done,
    output logic               div_by_zero
);

    localparam int N     = C_WIDTH + FIXED_POINT;
    localparam int RW    = C_WIDTH + 1;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

    state_t             state;
    state_t             state_next;
    logic [C_WIDTH-1:0] a_lat;
    logic [C_WIDTH-1:0] b_lat;
    logic               signed_lat;
    logic [C_WIDTH-1:0] b_mag;
    logic [N-1:0]       dividend;
    logic [N-1:0]       quot;
    logic [RW-1:0]      rem;
    logic [CNT_W-1:0]   count;
    logic               q_neg;
    logic               r_neg;

    logic [C_WIDTH-1:0] a_abs;
    logic [C_WIDTH-1:0] b_abs;
    logic [N-1:0]       a_ext;
    logic [RW-1:0]      rem_shift;
    logic [RW-1:0]      rem_sub;
    logic               take;
    logic [N-1:0]       q_signed;
    logic [C_WIDTH-1:0] r_mag;
    logic               b_zero;

    always_ff @(posedge ctl_clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = PREP;
            PREP:    state_next = b_zero ? FIX : CALC;
            CALC:    if (count == CNT_W'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready = (state == IDLE) && reset;

    always_comb begin
        b_zero    = (b_lat == '0);
        a_abs     = (signed_lat && a_lat[C_WIDTH-1]) ? -a_lat : a_lat;
        b_abs     = (signed_lat && b_lat[C_WIDTH-1]) ? -b_lat : b_lat;
        a_ext     = N'(a_abs);
        // The partial remainder is always below |b|, so one extra bit holds the shifted value.
        rem_shift = (rem << 1) | RW'(dividend[N-1]);
        take      = (rem_shift >= {1'b0, b_mag});
        rem_sub   = rem_shift - {1'b0, b_mag};
        q_signed  = q_neg ? -quot : quot;
        r_mag     = rem[C_WIDTH-1:0];
    end

    always_ff @(posedge ctl_clk) begin
        if (!reset) begin
            count       <= '0;
            y           <= '0;
            r           <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        a_lat      <= a;
                        b_lat      <= b;
                        signed_lat <= signed_cal;
                    end
                end
                PREP: begin
                    dividend <= a_ext << FIXED_POINT;
                    b_mag    <= b_abs;
                    rem      <= '0;
                    quot     <= '0;
                    count    <= CNT_W'(N);
                    q_neg    <= signed_lat & (a_lat[C_WIDTH-1] ^ b_lat[C_WIDTH-1]);
                    r_neg    <= signed_lat & a_lat[C_WIDTH-1];
                end
                CALC: begin
                    dividend <= dividend << 1;
                    rem      <= take ? rem_sub : rem_shift;
                    quot     <= {quot[N-2:0], take};
                    count    <= count - CNT_W'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    // Divide by zero returns all ones and hands the raw dividend back as remainder.
                    if (b_zero) begin
                        y           <= '1;
                        r           <= a_lat;
                        div_by_zero <= 1'b1;
                    end else begin
                        y           <= C_WIDTH'(q_signed);
                        r           <= r_neg ? -r_mag : r_mag;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the restoring divider, covering integer
// and 16-bit fixed-point instances with hand-computed expected results.
module tb_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b;
    logic        signed_cal, trigger;
    logic [31:0] y, r;
    logic        ready, done, div_by_zero;

    logic [31:0] a_fp, b_fp;
    logic        signed_fp, trigger_fp;
    logic [31:0] y_fp, r_fp;
    logic        ready_fp, done_fp, dbz_fp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    divider #(.C_WIDTH(32), .FIXED_POINT(0)) dut (
        .ctl_clk(clk), .reset(reset), .a(a), .b(b), .signed_cal(signed_cal),
        .trigger(trigger), .y(y), .r(r), .ready(ready), .done(done),
        .div_by_zero(div_by_zero)
    );

    divider #(.C_WIDTH(32), .FIXED_POINT(16)) dut_fp (
        .ctl_clk(clk), .reset(reset), .a(a_fp), .b(b_fp), .signed_cal(signed_fp),
        .trigger(trigger_fp), .y(y_fp), .r(r_fp), .ready(ready_fp), .done(done_fp),
        .div_by_zero(dbz_fp)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Starts one operation and waits for done; trigger is re-pulsed after edge pulse_at if nonzero.
    task automatic apply_stimulus(input logic [31:0] av, input logic [31:0] bv,
                                  input logic s, input int exp_edges,
                                  input int pulse_at, input string tag);
        int   edges;
        logic ready_low;
        @(negedge clk);
        a = av; b = bv; signed_cal = s; trigger = 1'b1;
        @(posedge clk); #1;
        a = $urandom; b = $urandom; signed_cal = ~s;
        trigger   = 1'b0;
        edges     = 1;
        ready_low = 1'b1;
        while (done !== 1'b1 && edges < 100) begin
            if (ready !== 1'b0) ready_low = 1'b0;
            trigger = (edges == pulse_at);
            @(posedge clk); #1;
            edges++;
        end
        trigger = 1'b0;
        check_output({tag, " latency"}, edges, exp_edges);
        check_output({tag, " ready low while busy"}, {31'b0, ready_low}, 32'd1);
        check_output({tag, " ready with done"}, {31'b0, ready}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [31:0] y_exp,
                                input logic [31:0] r_exp, input logic dbz_exp);
        check_output({tag, " y"}, y, y_exp);
        check_output({tag, " r"}, r, r_exp);
        check_output({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, dbz_exp});
    endtask

    initial begin
        int   edges;
        logic seen_done;
        reset = 1'b0; a = '0; b = '0; signed_cal = 1'b0; trigger = 1'b0;
        a_fp = '0; b_fp = '0; signed_fp = 1'b0; trigger_fp = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_result("reset", 32'h0, 32'h0, 1'b0);
        check_output("reset done", {31'b0, done}, 32'd0);
        check_output("reset ready", {31'b0, ready}, 32'd0);
        @(negedge clk); reset = 1'b1; #1;
        check_output("ready after reset", {31'b0, ready}, 32'd1);

        apply_stimulus(32'hee6c3250, 32'h1bca53c2, 1'b0, 35, 0, "unsigned big");
        check_result("unsigned big", 32'h00000008, 32'h10199440, 1'b0);
        @(posedge clk); #1;
        check_output("done one cycle", {31'b0, done}, 32'd0);
        check_output("y holds", y, 32'h00000008);

        apply_stimulus(32'h71, 32'hc2, 1'b0, 35, 0, "small over large");
        check_result("small over large", 32'h0, 32'h71, 1'b0);
        apply_stimulus(32'hFFFFFFF9, 32'h2, 1'b1, 35, 0, "neg over pos");
        check_result("neg over pos", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        apply_stimulus(32'h7, 32'hFFFFFFFE, 1'b1, 35, 0, "pos over neg");
        check_result("pos over neg", 32'hFFFFFFFD, 32'h1, 1'b0);

        apply_stimulus(32'h5, 32'h0, 1'b0, 3, 0, "div0 unsigned");
        check_result("div0 unsigned", 32'hFFFFFFFF, 32'h5, 1'b1);
        apply_stimulus(32'hFFFFFFF9, 32'h0, 1'b1, 3, 0, "div0 signed");
        check_result("div0 signed", 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);
        apply_stimulus(32'd100, 32'd7, 1'b0, 35, 0, "clear div0");
        check_result("clear div0", 32'd14, 32'd2, 1'b0);

        apply_stimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, 35, 0, "signed overflow");
        check_result("signed overflow", 32'h80000000, 32'h0, 1'b0);

        @(negedge clk);
        a_fp = 32'h00030000; b_fp = 32'h00020000; signed_fp = 1'b0; trigger_fp = 1'b1;
        @(posedge clk); #1;
        trigger_fp = 1'b0;
        edges = 1;
        while (done_fp !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        check_output("fixed point latency", edges, 32'd51);
        check_output("fixed point y", y_fp, 32'h00018000);
        check_output("fixed point r", r_fp, 32'h0);

        apply_stimulus(32'h12345678, 32'h1000, 1'b0, 35, 11, "retrigger ignored");
        check_result("retrigger ignored", 32'h00012345, 32'h00000678, 1'b0);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        check_output("no second done", {31'b0, seen_done}, 32'd0);

        @(negedge clk);
        a = 32'd100; b = 32'd7; signed_cal = 1'b0; trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check_result("abort", 32'h0, 32'h0, 1'b0);
        check_output("abort done", {31'b0, done}, 32'd0);
        check_output("abort ready low", {31'b0, ready}, 32'd0);
        @(negedge clk); reset = 1'b1; #1;
        check_output("abort ready high", {31'b0, ready}, 32'd1);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        check_output("abort no done", {31'b0, seen_done}, 32'd0);

        apply_stimulus(32'hFFFFFC18, 32'd3, 1'b1, 35, 0, "after abort");
        check_result("after abort", 32'hFFFFFEB3, 32'hFFFFFFFF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
